lane_balance_tracker: RTL and testbench

//  Tracks per-lane switched-bit activity over register writes in the vector unit.

---
 rtl/balance_pkg.sv | 18 +
 rtl/balance_abs_diff.sv | 19 +
 rtl/lane_balance_tracker.sv | 239 +++++++++++++++++++++++
 tb/tb_lane_balance_tracker.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/balance_pkg.sv
// Shared types and helpers for the lane balance tracker.
package balance_pkg;

    localparam int BAL_DATA_WIDTH = 32;
    localparam int BAL_SBIT_CNT_B = $clog2(BAL_DATA_WIDTH);

    typedef logic [BAL_SBIT_CNT_B:0] sbit_cnt_t;

    typedef enum logic {
        BAL_IDLE,
        BAL_CLEAR
    } bal_state_e;

    function automatic sbit_cnt_t abs_diff(sbit_cnt_t a, sbit_cnt_t b);
        return (a >= b) ? sbit_cnt_t'(a - b) : sbit_cnt_t'(b - a);
    endfunction

endpackage

// File: rtl/balance_abs_diff.sv
// Unsigned absolute difference of two set-bit counts.
module balance_abs_diff #(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o
);

    // Subtracting the smaller operand from the larger one cannot wrap.
    always_comb begin
        if (a_i >= b_i) begin
            diff_o = a_i - b_i;
        end else begin
            diff_o = b_i - a_i;
        end
    end

endmodule

// File: rtl/lane_balance_tracker.sv
// Per-lane switched-bit history and adjacent-lane imbalance tracker.
// Optional feature: define BALANCE_MASK_EN to add the per-lane active mask.
module lane_balance_tracker
    import balance_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SBIT_CNT_B = $clog2(DATA_WIDTH),
    parameter int LANES      = 4,
    parameter int ELEMS      = 4,
    parameter int REGS       = 32,
    parameter int EVT_CNT_W  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [$clog2(REGS)-1:0]           wr_reg_i,
    input  logic [$clog2(ELEMS)-1:0]          wr_elem_i,
    input  logic [LANES*(SBIT_CNT_B+1)-1:0]   lane_sbit_cnt_i,
`ifdef BALANCE_MASK_EN
    input  logic [LANES-1:0]                  lane_mask_i,
`endif
    input  logic [SBIT_CNT_B:0]               thresh_i,
    input  logic                              clear_i,
    output logic                              bal_valid_o,
    output logic [(LANES-1)*(SBIT_CNT_B+1)-1:0] balance_cnt_o,
    output logic                              imbalance_o,
    output logic [SBIT_CNT_B:0]               bal_max_o,
    output logic [EVT_CNT_W-1:0]              evt_cnt_o,
    output logic                              busy_o
);

    localparam int CW = SBIT_CNT_B + 1;
    localparam int RW = $clog2(REGS);

    logic [CW-1:0]        lane_cnt  [LANES];
    logic [CW-1:0]        hist_rd   [LANES];
    logic [CW-1:0]        delta_raw [LANES];
    logic [CW-1:0]        pair_raw  [LANES-1];
    logic [LANES-1:0]     lane_mask;
    logic                 accept;
    logic [CW-1:0]        cur_max;

    bal_state_e           state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 busy_q, busy_d;

    logic [CW-1:0]        hist_q [REGS][ELEMS][LANES];
    logic [CW-1:0]        hist_d [REGS][ELEMS][LANES];
    logic [CW-1:0]        delta_q [LANES];
    logic [CW-1:0]        delta_d [LANES];
    logic [LANES-1:0]     mask_q, mask_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [CW-1:0]        bal_q [LANES-1];
    logic [CW-1:0]        bal_d [LANES-1];
    logic                 imb_q, imb_d;
    logic                 bal_valid_q, bal_valid_d;
    logic [CW-1:0]        max_q, max_d;
    logic [EVT_CNT_W-1:0] evt_q, evt_d;

`ifdef BALANCE_MASK_EN
    assign lane_mask = lane_mask_i;
`else
    assign lane_mask = '1;
`endif

    // A clear request wins over a write presented in the same cycle.
    assign wr_ready_o = rst_ni & (state_q == BAL_IDLE) & ~clear_i;
    assign accept     = wr_valid_i & wr_ready_o;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_cnt[l] = lane_sbit_cnt_i[l*CW +: CW];
        assign hist_rd[l]  = hist_q[wr_reg_i][wr_elem_i][l];
        balance_abs_diff #(.W(CW)) u_delta (
            .a_i    (lane_cnt[l]),
            .b_i    (hist_rd[l]),
            .diff_o (delta_raw[l])
        );
    end

    for (genvar i = 0; i < LANES-1; i++) begin : g_pair
        balance_abs_diff #(.W(CW)) u_bal (
            .a_i    (delta_q[i]),
            .b_i    (delta_q[i+1]),
            .diff_o (pair_raw[i])
        );
        assign balance_cnt_o[i*CW +: CW] = bal_q[i];
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            BAL_IDLE: begin
                if (clear_i) begin
                    state_d = BAL_CLEAR;
                    row_d   = '0;
                end
            end
            BAL_CLEAR: begin
                if (row_q == RW'(REGS-1)) begin
                    state_d = BAL_IDLE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: state_d = BAL_IDLE;
        endcase
        busy_d = (state_d == BAL_CLEAR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BAL_IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
        end
    end

    // Writes never overlap the sweep: none are accepted while clearing.
    always_comb begin
        hist_d = hist_q;
        if (state_q == BAL_CLEAR) begin
            for (int e = 0; e < ELEMS; e++) begin
                for (int l = 0; l < LANES; l++) begin
                    hist_d[row_q][e][l] = '0;
                end
            end
        end else if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_mask[l]) begin
                    hist_d[wr_reg_i][wr_elem_i][l] = lane_cnt[l];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < REGS; r++) begin
                for (int e = 0; e < ELEMS; e++) begin
                    for (int l = 0; l < LANES; l++) begin
                        hist_q[r][e][l] <= '0;
                    end
                end
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    always_comb begin
        s1_valid_d = accept;
        mask_d     = accept ? lane_mask : mask_q;
        for (int l = 0; l < LANES; l++) begin
            delta_d[l] = delta_q[l];
            if (accept) begin
                delta_d[l] = lane_mask[l] ? delta_raw[l] : '0;
            end
        end
    end

    // Pairs touching a masked lane report zero and can never flag.
    always_comb begin
        bal_valid_d = s1_valid_q;
        imb_d       = imb_q;
        for (int i = 0; i < LANES-1; i++) begin
            bal_d[i] = bal_q[i];
        end
        if (s1_valid_q) begin
            imb_d = 1'b0;
            for (int i = 0; i < LANES-1; i++) begin
                bal_d[i] = (mask_q[i] & mask_q[i+1]) ? pair_raw[i] : '0;
                if (bal_d[i] > thresh_i) begin
                    imb_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        max_d   = max_q;
        evt_d   = evt_q;
        cur_max = '0;
        for (int i = 0; i < LANES-1; i++) begin
            if (bal_q[i] > cur_max) begin
                cur_max = bal_q[i];
            end
        end
        if ((state_q == BAL_IDLE) && clear_i) begin
            max_d = '0;
            evt_d = '0;
        end else if ((state_q == BAL_IDLE) && bal_valid_q) begin
            if (cur_max > max_q) begin
                max_d = cur_max;
            end
            if (imb_q && (evt_q != '1)) begin
                evt_d = evt_q + EVT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < LANES; l++) begin
                delta_q[l] <= '0;
            end
            for (int i = 0; i < LANES-1; i++) begin
                bal_q[i] <= '0;
            end
            mask_q      <= '0;
            s1_valid_q  <= 1'b0;
            imb_q       <= 1'b0;
            bal_valid_q <= 1'b0;
            max_q       <= '0;
            evt_q       <= '0;
        end else begin
            delta_q     <= delta_d;
            bal_q       <= bal_d;
            mask_q      <= mask_d;
            s1_valid_q  <= s1_valid_d;
            imb_q       <= imb_d;
            bal_valid_q <= bal_valid_d;
            max_q       <= max_d;
            evt_q       <= evt_d;
        end
    end

    assign bal_valid_o = bal_valid_q;
    assign imbalance_o = imb_q;
    assign bal_max_o   = max_q;
    assign evt_cnt_o   = evt_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_lane_balance_tracker.sv
// Self-checking bench for lane_balance_tracker against a plain-arithmetic reference model.
// Define BALANCE_MASK_EN to also exercise the lane mask.
module tb_lane_balance_tracker;

    localparam int CW      = 6;
    localparam int LANES   = 4;
    localparam int REGS    = 32;
    localparam int ELEMS   = 4;
    localparam int EVT_W   = 4;
    localparam int EVT_MAX = (1 << EVT_W) - 1;
    localparam int THRESH  = 8;

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic                        wr_valid_i;
    logic                        wr_ready_o;
    logic [4:0]                  wr_reg_i;
    logic [1:0]                  wr_elem_i;
    logic [LANES*CW-1:0]         lane_sbit_cnt_i;
    logic [LANES-1:0]            lane_mask_i;
    logic [CW-1:0]               thresh_i;
    logic                        clear_i;
    logic                        bal_valid_o;
    logic [(LANES-1)*CW-1:0]     balance_cnt_o;
    logic                        imbalance_o;
    logic [CW-1:0]               bal_max_o;
    logic [EVT_W-1:0]            evt_cnt_o;
    logic                        busy_o;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int hist_m [REGS][ELEMS][LANES];
    int max_m;
    int evt_m;
    logic [18:0] exp_q [$];
    logic [18:0] obs_q [$];

    always #5 clk_i = ~clk_i;

    lane_balance_tracker #(
        .DATA_WIDTH (32),
        .LANES      (LANES),
        .ELEMS      (ELEMS),
        .REGS       (REGS),
        .EVT_CNT_W  (EVT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_reg_i        (wr_reg_i),
        .wr_elem_i       (wr_elem_i),
        .lane_sbit_cnt_i (lane_sbit_cnt_i),
`ifdef BALANCE_MASK_EN
        .lane_mask_i     (lane_mask_i),
`endif
        .thresh_i        (thresh_i),
        .clear_i         (clear_i),
        .bal_valid_o     (bal_valid_o),
        .balance_cnt_o   (balance_cnt_o),
        .imbalance_o     (imbalance_o),
        .bal_max_o       (bal_max_o),
        .evt_cnt_o       (evt_cnt_o),
        .busy_o          (busy_o)
    );

    // Every emitted result is recorded; the scenario tasks compare it later.
    always @(negedge clk_i) begin
        if (rst_ni && bal_valid_o) begin
            obs_q.push_back({balance_cnt_o, imbalance_o});
        end
    end

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic void model_reset();
        foreach (hist_m[r, e, l]) hist_m[r][e][l] = 0;
        max_m = 0;
        evt_m = 0;
        exp_q.delete();
        obs_q.delete();
    endfunction

    function automatic void model_write(int r, int e, int c0, int c1, int c2, int c3, logic [3:0] m);
        int c [4];
        int d [4];
        int b;
        int bmax;
        logic imb;
        logic [18:0] ent;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int l = 0; l < 4; l++) begin
            d[l] = m[l] ? iabs(c[l] - hist_m[r][e][l]) : 0;
            if (m[l]) hist_m[r][e][l] = c[l];
        end
        imb  = 1'b0;
        bmax = 0;
        ent  = '0;
        for (int i = 0; i < 3; i++) begin
            b = (m[i] && m[i+1]) ? iabs(d[i] - d[i+1]) : 0;
            if (b > THRESH) imb = 1'b1;
            if (b > bmax) bmax = b;
            ent[1 + i*CW +: CW] = CW'(b);
        end
        ent[0] = imb;
        exp_q.push_back(ent);
        if (bmax > max_m) max_m = bmax;
        if (imb && evt_m < EVT_MAX) evt_m++;
    endfunction

    // Presents one write starting just after a rising edge; returns just after the next one.
    task automatic drive_write(input int r, input int e, input int c0, input int c1,
                               input int c2, input int c3, input logic [3:0] m);
        logic acc;
        wr_valid_i      = 1'b1;
        wr_reg_i        = r[4:0];
        wr_elem_i       = e[1:0];
        lane_sbit_cnt_i = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
        lane_mask_i     = m;
        #3 acc = wr_ready_o;
        @(posedge clk_i);
        if (acc) model_write(r, e, c0, c1, c2, c3, m);
        #1 wr_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; wr_valid_i = 1'b0; clear_i = 1'b0;
        wr_reg_i = '0; wr_elem_i = '0; lane_sbit_cnt_i = '0; lane_mask_i = '1;
        thresh_i = CW'(THRESH);
        repeat (3) tick();
        check_cnt++; if (bal_valid_o !== 1'b0) $display("[TB] FAIL reset_bal_valid got %0b want 0", bal_valid_o); else pass_cnt++;
        check_cnt++; if (balance_cnt_o !== '0) $display("[TB] FAIL reset_balance got %h want 0", balance_cnt_o); else pass_cnt++;
        check_cnt++; if (imbalance_o !== 1'b0) $display("[TB] FAIL reset_imbalance got %0b want 0", imbalance_o); else pass_cnt++;
        check_cnt++; if (bal_max_o !== '0) $display("[TB] FAIL reset_bal_max got %0d want 0", bal_max_o); else pass_cnt++;
        check_cnt++; if (evt_cnt_o !== '0) $display("[TB] FAIL reset_evt got %0d want 0", evt_cnt_o); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", busy_o); else pass_cnt++;
        rst_ni = 1'b1;
        tick();
        check_cnt++; if (wr_ready_o !== 1'b1) $display("[TB] FAIL reset_ready got %0b want 1", wr_ready_o); else pass_cnt++;
        model_reset();
    endtask

    task automatic test_basic();
        drive_write(3, 0, 4, 4, 4, 4, 4'hF);
        check_cnt++; if (bal_valid_o !== 1'b0) $display("[TB] FAIL basic_early_valid got %0b want 0", bal_valid_o); else pass_cnt++;
        tick();
        check_cnt++; if (bal_valid_o !== 1'b1) $display("[TB] FAIL basic_valid got %0b want 1", bal_valid_o); else pass_cnt++;
        check_cnt++; if (balance_cnt_o !== '0) $display("[TB] FAIL basic_balance got %h want 0", balance_cnt_o); else pass_cnt++;
        check_cnt++; if (imbalance_o !== 1'b0) $display("[TB] FAIL basic_imbalance got %0b want 0", imbalance_o); else pass_cnt++;
        tick();
        check_cnt++; if (bal_valid_o !== 1'b0) $display("[TB] FAIL basic_valid_pulse got %0b want 0", bal_valid_o); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        drive_write(3, 0, 4, 4, 4, 4, 4'hF);
        drive_write(3, 0, 20, 4, 4, 4, 4'hF);
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size()) $display("[TB] FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check_cnt++;
            if (obs_q[k] !== exp_q[k]) $display("[TB] FAIL b2b_result[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
            else pass_cnt++;
        end
        check_cnt++; if (bal_max_o !== CW'(max_m)) $display("[TB] FAIL b2b_bal_max got %0d want %0d", bal_max_o, max_m); else pass_cnt++;
        check_cnt++; if (evt_cnt_o !== EVT_W'(evt_m)) $display("[TB] FAIL b2b_evt got %0d want %0d", evt_cnt_o, evt_m); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_full_swing();
        drive_write(5, 2, 32, 0, 32, 0, 4'hF);
        drive_write(5, 2, 32, 0, 32, 0, 4'hF);
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size()) $display("[TB] FAIL swing_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check_cnt++;
            if (obs_q[k] !== exp_q[k]) $display("[TB] FAIL swing_result[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
            else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            drive_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 32),
                        $urandom_range(0, 32), $urandom_range(0, 32), $urandom_range(0, 32), 4'hF);
            if ($urandom_range(0, 4) == 0) tick();
        end
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size()) $display("[TB] FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check_cnt++;
            if (obs_q[k] !== exp_q[k]) $display("[TB] FAIL rand_result[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
            else pass_cnt++;
        end
        check_cnt++; if (bal_max_o !== CW'(max_m)) $display("[TB] FAIL rand_bal_max got %0d want %0d", bal_max_o, max_m); else pass_cnt++;
        check_cnt++; if (evt_cnt_o !== EVT_W'(evt_m)) $display("[TB] FAIL rand_evt got %0d want %0d", evt_cnt_o, evt_m); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_clear();
        int  busy_cyc  = 0;
        int  ready_bad = 0;
        bit  done      = 1'b0;
        drive_write(7, 1, 10, 2, 30, 5, 4'hF);
        drive_write(8, 3, 1, 25, 3, 17, 4'hF);
        // Clear and a write arrive together: the write must be refused.
        clear_i         = 1'b1;
        wr_valid_i      = 1'b1;
        wr_reg_i        = 5'd9;
        lane_sbit_cnt_i = {CW'(9), CW'(9), CW'(9), CW'(9)};
        #1;
        check_cnt++; if (wr_ready_o !== 1'b0) $display("[TB] FAIL clear_ready_prio got %0b want 0", wr_ready_o); else pass_cnt++;
        @(posedge clk_i);
        #1 clear_i = 1'b0; wr_valid_i = 1'b0;
        foreach (hist_m[r, e, l]) hist_m[r][e][l] = 0;
        max_m = 0;
        evt_m = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_i);
            if (k == 10) clear_i = 1'b1;
            if (k == 11) clear_i = 1'b0;
            if (busy_o) begin
                busy_cyc++;
                if (wr_ready_o) ready_bad++;
            end else begin
                done = 1'b1;
            end
        end
        check_cnt++; if (!done) $display("[TB] FAIL clear_timeout got busy after 100 cycles want idle"); else pass_cnt++;
        check_cnt++; if (busy_cyc != REGS) $display("[TB] FAIL clear_busy_len got %0d want %0d", busy_cyc, REGS); else pass_cnt++;
        check_cnt++; if (ready_bad != 0) $display("[TB] FAIL clear_ready_low got %0d ready cycles want 0", ready_bad); else pass_cnt++;
        check_cnt++;
        if (obs_q.size() != exp_q.size()) $display("[TB] FAIL clear_inflight_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check_cnt++;
            if (obs_q[k] !== exp_q[k]) $display("[TB] FAIL clear_inflight[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
            else pass_cnt++;
        end
        check_cnt++; if (bal_max_o !== '0) $display("[TB] FAIL clear_bal_max got %0d want 0", bal_max_o); else pass_cnt++;
        check_cnt++; if (evt_cnt_o !== '0) $display("[TB] FAIL clear_evt got %0d want 0", evt_cnt_o); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
        tick();
        drive_write(3, 0, 20, 4, 4, 4, 4'hF);
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
            $display("[TB] FAIL clear_rewrite got %0d results first %h want %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 19'h0, exp_q[0]);
        else pass_cnt++;
        check_cnt++; if (bal_max_o !== CW'(max_m)) $display("[TB] FAIL clear_rewrite_max got %0d want %0d", bal_max_o, max_m); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_evt_saturate();
        for (int n = 0; n < 20; n++) begin
            if (n % 2 == 0) drive_write(3, 0, 4, 4, 4, 4, 4'hF);
            else            drive_write(3, 0, 20, 4, 4, 4, 4'hF);
        end
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size()) $display("[TB] FAIL sat_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check_cnt++;
            if (obs_q[k] !== exp_q[k]) $display("[TB] FAIL sat_result[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
            else pass_cnt++;
        end
        check_cnt++; if (evt_cnt_o !== EVT_W'(evt_m)) $display("[TB] FAIL sat_evt got %0d want %0d", evt_cnt_o, evt_m); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
    endtask

`ifdef BALANCE_MASK_EN
    task automatic test_mask();
        drive_write(1, 1, 8, 30, 0, 8, 4'b1101);
        drive_write(1, 1, 8, 0, 0, 8, 4'hF);
        for (int n = 0; n < 60; n++) begin
            drive_write($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 32),
                        $urandom_range(0, 32), $urandom_range(0, 32), $urandom_range(0, 32),
                        4'($urandom_range(0, 15)));
        end
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size()) $display("[TB] FAIL mask_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check_cnt++;
            if (obs_q[k] !== exp_q[k]) $display("[TB] FAIL mask_result[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
            else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    task automatic test_reset_mid_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        repeat (5) tick();
        check_cnt++; if (busy_o !== 1'b1) $display("[TB] FAIL midclr_busy_before got %0b want 1", busy_o); else pass_cnt++;
        rst_ni = 1'b0;
        #1;
        check_cnt++; if (busy_o !== 1'b0) $display("[TB] FAIL midclr_busy_after_reset got %0b want 0", busy_o); else pass_cnt++;
        tick();
        rst_ni = 1'b1;
        tick();
        check_cnt++; if (wr_ready_o !== 1'b1) $display("[TB] FAIL midclr_ready got %0b want 1", wr_ready_o); else pass_cnt++;
        model_reset();
        drive_write(3, 0, 20, 4, 4, 4, 4'hF);
        repeat (4) tick();
        check_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
            $display("[TB] FAIL midclr_rewrite got %0d results first %h want %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 19'h0, exp_q[0]);
        else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no finish want finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full_swing();
        test_random();
        test_clear();
        test_evt_saturate();
`ifdef BALANCE_MASK_EN
        test_mask();
`endif
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
